// File: rtl/tap_master.sv
// JTAG TAP master: sequences TAP-reset, IR-scan and DR-scan commands with TCK = CLK/2,
// shifting DataIn out on TDI (LSB first) and capturing TDO into DataOut.
module tap_master #(
  parameter int unsigned MAXLEN = 24,
  parameter int unsigned IRLEN  = 3
) (
  input  logic              CLK,
  input  logic              RstBar,
  input  logic              Start,
  input  logic [1:0]        Op,
  input  logic [4:0]        Len,
  input  logic [MAXLEN-1:0] DataIn,
  input  logic              TDO,
  output logic              TCK,
  output logic              TMS,
  output logic              TDI,
  output logic              Busy,
  output logic              Done,
  output logic [MAXLEN-1:0] DataOut
);
  localparam int unsigned CW = $clog2(MAXLEN + IRLEN + 8);
  localparam int unsigned BW = $clog2(MAXLEN);

  localparam logic [1:0] OP_RST = 2'b00;
  localparam logic [1:0] OP_IR  = 2'b01;
  localparam logic [1:0] OP_DR  = 2'b10;
  localparam logic [1:0] OP_NOP = 2'b11;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Pulses before the first shift bit: Select-DR(,Select-IR),Capture,Shift entry
  function automatic logic [CW-1:0] pre_of(input logic [1:0] op);
    return (op == OP_IR) ? CW'(4) : CW'(3);
  endfunction

  function automatic logic shift_at(input logic [1:0] op, input logic [CW-1:0] n,
                                    input logic [CW-1:0] p);
    return (op != OP_RST) && (p >= pre_of(op)) && (p < pre_of(op) + n);
  endfunction

  function automatic logic tms_at(input logic [1:0] op, input logic [CW-1:0] n,
                                  input logic [CW-1:0] p);
    logic [CW-1:0] pre;
    logic          tms;
    pre = pre_of(op);
    if (op == OP_RST)       tms = (p < CW'(5));
    else if (p < pre)       tms = (op == OP_IR) ? (p < CW'(2)) : (p == '0);
    else if (p < pre + n)   tms = (p == pre + n - CW'(1));
    else                    tms = (p == pre + n);
    return tms;
  endfunction

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic [CW-1:0]     n_q, n_d, n_in, pcnt_q, pcnt_d, last_pulse;
  logic [BW-1:0]     bidx_q, bidx_d;
  logic [MAXLEN-1:0] sh_q, sh_d, cap_q, cap_d, dout_q, dout_d;
  logic              tck_q, tck_d, tms_q, tms_d, tdi_q, tdi_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic              complete, new_shift, nxt_shift;

  always_ff @(posedge CLK or negedge RstBar) begin
    if (!RstBar) begin
      state_q <= IDLE;
      op_q    <= OP_RST;
      n_q     <= '0;
      pcnt_q  <= '0;
      bidx_q  <= '0;
      sh_q    <= '0;
      cap_q   <= '0;
      tck_q   <= 1'b0;
      tms_q   <= 1'b1;
      tdi_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      n_q     <= n_d;
      pcnt_q  <= pcnt_d;
      bidx_q  <= bidx_d;
      sh_q    <= sh_d;
      cap_q   <= cap_d;
      tck_q   <= tck_d;
      tms_q   <= tms_d;
      tdi_q   <= tdi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    n_d      = n_q;
    pcnt_d   = pcnt_q;
    bidx_d   = bidx_q;
    sh_d     = sh_q;
    cap_d    = cap_q;
    tck_d    = tck_q;
    tms_d    = tms_q;
    tdi_d    = tdi_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dout_d   = dout_q;
    complete = 1'b0;

    // Shift length of an incoming command, clamped to 1..MAXLEN
    if (Op == OP_IR)                  n_in = CW'(IRLEN);
    else if (Len == 5'd0)             n_in = CW'(1);
    else if (CW'(Len) > CW'(MAXLEN))  n_in = CW'(MAXLEN);
    else                              n_in = CW'(Len);

    last_pulse = (op_q == OP_RST) ? CW'(5) : pre_of(op_q) + n_q + CW'(1);
    new_shift  = shift_at(Op, n_in, '0);
    nxt_shift  = shift_at(op_q, n_q, pcnt_q + CW'(1));

    case (state_q)
      IDLE, DONE: begin
        if (state_q == DONE) state_d = IDLE;
        if (Start) begin
          state_d = RUN;
          op_d    = Op;
          n_d     = n_in;
          pcnt_d  = '0;
          bidx_d  = '0;
          cap_d   = '0;
          busy_d  = 1'b1;
          tck_d   = 1'b0;
          sh_d    = new_shift ? (DataIn >> 1) : DataIn;
          if (Op != OP_NOP) begin
            tms_d = tms_at(Op, n_in, '0);
            tdi_d = new_shift & DataIn[0];
          end
        end
      end
      RUN: begin
        if (op_q == OP_NOP) begin
          complete = 1'b1;
        end else if (!tck_q) begin
          tck_d = 1'b1;
          if (shift_at(op_q, n_q, pcnt_q)) begin
            cap_d[bidx_q] = TDO;
            bidx_d        = bidx_q + BW'(1);
          end
        end else if (pcnt_q == last_pulse) begin
          complete = 1'b1;
        end else begin
          tck_d  = 1'b0;
          pcnt_d = pcnt_q + CW'(1);
          tms_d  = tms_at(op_q, n_q, pcnt_q + CW'(1));
          tdi_d  = nxt_shift & sh_q[0];
          if (nxt_shift) sh_d = sh_q >> 1;
        end
        // Park in Run-Test/Idle with TCK/TMS low
        if (complete) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          tck_d   = 1'b0;
          tms_d   = 1'b0;
          tdi_d   = 1'b0;
          if (op_q == OP_IR || op_q == OP_DR) dout_d = cap_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign TCK     = tck_q;
  assign TMS     = tms_q;
  assign TDI     = tdi_q;
  assign Busy    = busy_q;
  assign Done    = done_q;
  assign DataOut = dout_q;

endmodule
